// File: rtl/dm_pipe_mem_pkg.sv
// Shared encodings for the MEM-stage data memory: FSM states, load types,
// store sizes, and the byte-lane helpers used by the store path.
package dm_pipe_mem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RESP  = 2'd2
   } dm_state_e;

   localparam logic [2:0] MEM_R_LW  = 3'd0;
   localparam logic [2:0] MEM_R_LH  = 3'd1;
   localparam logic [2:0] MEM_R_LHU = 3'd2;
   localparam logic [2:0] MEM_R_LB  = 3'd3;
   localparam logic [2:0] MEM_R_LBU = 3'd4;

   localparam logic [1:0] DM_WB_SW  = 2'b00;
   localparam logic [1:0] DM_WB_SH  = 2'b01;
   localparam logic [1:0] DM_WB_SB  = 2'b10;
   localparam logic [1:0] DM_WB_NOP = 2'b11;

   function automatic logic [3:0] store_mask(input logic [1:0] wbits, input logic [1:0] lo);
      case (wbits)
         DM_WB_SW: return 4'b1111;
         DM_WB_SH: return lo[1] ? 4'b1100 : 4'b0011;
         DM_WB_SB: return 4'b0001 << lo;
         default:  return 4'b0000;
      endcase
   endfunction

   // Replicate the narrow store data across every lane; the mask picks the live one.
   function automatic logic [31:0] store_lanes(input logic [1:0] wbits, input logic [31:0] wdata);
      case (wbits)
         DM_WB_SH: return {2{wdata[15:0]}};
         DM_WB_SB: return {4{wdata[7:0]}};
         default:  return wdata;
      endcase
   endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load lane select and sign/zero extension for lw/lh/lhu/lb/lbu.
module dm_load_align
   import dm_pipe_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  rbits,
   output logic [31:0] result
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      half_sel = addr[1] ? word[31:16] : word[15:0];
      byte_sel = word[7:0];
      result   = '0;
      case (addr)
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      case (rbits)
         MEM_R_LW:  result = word;
         MEM_R_LH:  result = {{16{half_sel[15]}}, half_sel};
         MEM_R_LHU: result = {16'h0, half_sel};
         MEM_R_LB:  result = {{24{byte_sel[7]}}, byte_sel};
         MEM_R_LBU: result = {24'h0, byte_sel};
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/dm_pipe_mem.sv
// MEM-stage data memory with valid/ready request/response and post-reset clear sweep.
// Define DM_MISALIGN_TRAP_EN to flag misaligned word/half accesses as errors.
module dm_pipe_mem
   import dm_pipe_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DEPTH      = 512,
   parameter bit CLR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_wbits,
   input  logic [2:0]        req_rbits,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int IDX_W = $clog2(DEPTH);

   dm_state_e        state, state_nxt;
   logic [IDX_W-1:0] clr_cnt;
   logic [31:0]      mem [DEPTH];

   logic             accept, in_range, misalign, err, wr_en;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      rd_word, ld_data, wr_lanes;
   logic [3:0]       wr_mask;

   assign rsp_valid = (state == ST_RESP);
   assign req_ready = (state != ST_CLEAR) && (!rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign word_idx  = req_addr[IDX_W+1:2];
   assign in_range  = (req_addr >> (IDX_W + 2)) == '0;

`ifdef DM_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      if (req_we)
         misalign = (req_wbits == DM_WB_SW && req_addr[1:0] != 2'b00) ||
                    (req_wbits == DM_WB_SH && req_addr[0]);
      else
         misalign = (req_rbits == MEM_R_LW && req_addr[1:0] != 2'b00) ||
                    ((req_rbits == MEM_R_LH || req_rbits == MEM_R_LHU) && req_addr[0]);
   end
`else
   assign misalign = 1'b0;
`endif

   assign err      = !in_range || misalign;
   assign wr_en    = accept && req_we && !err;
   assign wr_mask  = store_mask(req_wbits, req_addr[1:0]);
   assign wr_lanes = store_lanes(req_wbits, req_wdata);
   assign rd_word  = mem[word_idx];

   dm_load_align u_align (
      .word   (rd_word),
      .addr   (req_addr[1:0]),
      .rbits  (req_rbits),
      .result (ld_data)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (!CLR_ON_RST || clr_cnt == IDX_W'(DEPTH - 1)) state_nxt = ST_IDLE;
         ST_IDLE:  if (accept) state_nxt = ST_RESP;
         ST_RESP:  if (rsp_ready && !accept) state_nxt = ST_IDLE;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   // NOTE: the array has no reset; its contents are cleared by the sweep instead.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         if (CLR_ON_RST) mem[clr_cnt] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (wr_mask[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_CLEAR;
         clr_cnt   <= '0;
         init_done <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (state == ST_CLEAR && state_nxt == ST_IDLE) init_done <= 1'b1;
         if (accept) begin
            rsp_err   <= err;
            rsp_rdata <= (req_we || err) ? '0 : ld_data;
         end
      end
   end

endmodule
